// File: rtl/axis_steer_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_steer_ctrl
//
// Steering front-end for a 2-port AXI4-Stream demux. Incoming beats pass
// through a 2-entry skid buffer. A route is chosen once per frame, either from
// tdest[0] or by round-robin. The demux sel/drop controls are stored with each
// beat, so they stay aligned with the head beat and constant for the whole
// frame. Per-port forwarded-frame counters and a dropped-frame counter are
// also kept.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axis_*            input stream (tdata/tkeep/tvalid/tready/tlast/tdest/tuser)
//   m_axis_*            registered stream to the demux
//   sel, drop           demux port select / drop, aligned with the m_axis head beat
//   cfg_enable          0 = accept no new frames (a frame in progress completes)
//   cfg_rr_en           1 = round-robin routing, 0 = tdest[0] routing
//   cfg_drop_mask       bit i set = drop frames routed to port i
//   stat_clear          synchronous clear of all counters
//   stat_frames         forwarded frames, port0 in [COUNT_WIDTH-1:0]
//   stat_dropped        frames marked drop
// -----------------------------------------------------------------------------
module axis_steer_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic                     sel,
  output logic                     drop,
  input  logic                     cfg_enable,
  input  logic                     cfg_rr_en,
  input  logic [1:0]               cfg_drop_mask,
  input  logic                     stat_clear,
  output logic [2*COUNT_WIDTH-1:0] stat_frames,
  output logic [COUNT_WIDTH-1:0]   stat_dropped
);

  typedef enum logic {IDLE, FRAME} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
  } beat_t;

  state_t                 state;
  logic [1:0]             count;
  logic                   rr_ptr;
  logic                   cur_sel;
  logic                   cur_drop;

  beat_t                  in_beat;
  beat_t                  buf0;
  beat_t                  buf1;
  logic                   sel0, sel1;
  logic                   drop0, drop1;

  logic [COUNT_WIDTH-1:0] frames0;
  logic [COUNT_WIDTH-1:0] frames1;
  logic [COUNT_WIDTH-1:0] dropped;

  logic                   push;
  logic                   pop;
  logic                   start;
  logic                   route;
  logic                   route_drop;
  logic                   beat_sel;
  logic                   beat_drop;
  logic                   ld0;
  logic                   ld0_in;
  logic                   ld1;

  assign in_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast,
                     tdest: s_axis_tdest, tuser: s_axis_tuser};

  // Ready depends only on registered state and config, never on m_axis_tready.
  assign s_axis_tready = !rst && (count != 2'd2) && ((state == FRAME) || cfg_enable);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Route chosen on the first beat of a frame; later beats reuse the latched one.
  assign start      = (state == IDLE);
  assign route      = cfg_rr_en ? rr_ptr : s_axis_tdest[0];
  assign route_drop = cfg_drop_mask[route];
  assign beat_sel   = start ? route      : cur_sel;
  assign beat_drop  = start ? route_drop : cur_drop;

  // Head entry is loaded from the input when the buffer is empty or when a
  // single entry is being replaced, and from the second entry when full.
  assign ld0    = (push && ((count == 2'd0) || ((count == 2'd1) && pop))) ||
                  (pop && (count == 2'd2));
  assign ld0_in = (count != 2'd2);
  assign ld1    = push && (count == 2'd1) && !pop;

  // Data path: payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (ld0) buf0 <= ld0_in ? in_beat : buf1;
    if (ld1) buf1 <= in_beat;
  end

  // Control: occupancy, frame state, routing, stored sel/drop and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      cur_sel  <= 1'b0;
      cur_drop <= 1'b0;
      sel0     <= 1'b0;
      sel1     <= 1'b0;
      drop0    <= 1'b0;
      drop1    <= 1'b0;
      frames0  <= '0;
      frames1  <= '0;
      dropped  <= '0;
    end else begin
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;

      if (push) begin
        if (start) begin
          cur_sel  <= route;
          cur_drop <= route_drop;
          if (cfg_rr_en) rr_ptr <= ~rr_ptr;
        end
        state <= s_axis_tlast ? IDLE : FRAME;
      end

      if (ld0) begin
        sel0  <= ld0_in ? beat_sel  : sel1;
        drop0 <= ld0_in ? beat_drop : drop1;
      end
      if (ld1) begin
        sel1  <= beat_sel;
        drop1 <= beat_drop;
      end

      // Clear takes priority over a same-cycle increment.
      if (stat_clear) begin
        frames0 <= '0;
        frames1 <= '0;
        dropped <= '0;
      end else if (push && s_axis_tlast) begin
        if (beat_drop)     dropped <= dropped + 1'b1;
        else if (beat_sel) frames1 <= frames1 + 1'b1;
        else               frames0 <= frames0 + 1'b1;
      end
    end
  end

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = buf0.tdata;
  assign m_axis_tkeep  = buf0.tkeep;
  assign m_axis_tlast  = buf0.tlast;
  assign m_axis_tdest  = buf0.tdest;
  assign m_axis_tuser  = buf0.tuser;
  assign sel           = sel0;
  assign drop          = drop0;

  assign stat_frames   = {frames1, frames0};
  assign stat_dropped  = dropped;

endmodule

// File: tb/tb_axis_steer_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for axis_steer_ctrl (COUNT_WIDTH=2 so counter wrap is reachable).
module tb_axis_steer_ctrl;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int DSW = 8;
  localparam int UW  = 1;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_tdata;
  logic [KW-1:0]  s_tkeep;
  logic           s_tvalid;
  logic           s_tready;
  logic           s_tlast;
  logic [DSW-1:0] s_tdest;
  logic [UW-1:0]  s_tuser;
  logic [DW-1:0]  m_tdata;
  logic [KW-1:0]  m_tkeep;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic [DSW-1:0] m_tdest;
  logic [UW-1:0]  m_tuser;
  logic           sel;
  logic           drop;
  logic           cfg_enable;
  logic           cfg_rr_en;
  logic [1:0]     cfg_drop_mask;
  logic           stat_clear;
  logic [2*CW-1:0] stat_frames;
  logic [CW-1:0]  stat_dropped;

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp_q[$];

  axis_steer_ctrl #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser),
    .sel(sel), .drop(drop),
    .cfg_enable(cfg_enable), .cfg_rr_en(cfg_rr_en), .cfg_drop_mask(cfg_drop_mask),
    .stat_clear(stat_clear), .stat_frames(stat_frames), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat image: {tdata, tkeep, tdest, tuser, tlast, sel, drop}; tkeep/tuser derive from data.
  function automatic logic [47:0] pack(input logic [31:0] d, input logic l,
                                       input logic [7:0] dest, input logic s, input logic dr);
    return {d, d[3:0], dest, d[0], l, s, dr};
  endfunction

  // Output scoreboard: every transferred beat must match the next hand-written expectation.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else chk("beat", {m_tdata, m_tkeep, m_tdest, m_tuser, m_tlast, sel, drop}, exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic [7:0] dest);
    logic acc;
    acc      = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = d[3:0];
    s_tuser  = d[0];
    s_tlast  = l;
    s_tdest  = dest;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [7:0] dest,
                      input logic s, input logic dr);
    exp_q.push_back(pack(d, l, dest, s, dr));
    send_beat(d, l, dest);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdest = '0; s_tuser = '0; m_tready = 1'b0; cfg_enable = 1'b1; cfg_rr_en = 1'b0;
    cfg_drop_mask = 2'b00; stat_clear = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_sel_drop", {sel, drop}, 0);
    chk("rst_stats", {stat_frames, stat_dropped}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // tdest routing and 1-cycle latency
    m_tready = 1'b1;
    chk("pre_tvalid", m_tvalid, 0);
    beat(32'h11, 1'b0, 8'd1, 1'b1, 1'b0);
    chk("lat_tvalid", m_tvalid, 1);
    chk("lat_tdata", m_tdata, 32'h11);
    beat(32'h12, 1'b0, 8'd1, 1'b1, 1'b0);
    beat(32'h13, 1'b1, 8'd1, 1'b1, 1'b0);
    beat(32'h20, 1'b1, 8'd0, 1'b0, 1'b0);
    drain();
    chk("t1_frames", stat_frames, 4'b0101);
    chk("t1_dropped", stat_dropped, 0);

    // Round-robin: four 2-beat frames, tdest=0
    clear_stats();
    chk("clear", stat_frames, 0);
    cfg_rr_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      beat(32'h30 + 2 * f, 1'b0, 8'd0, f[0], 1'b0);
      beat(32'h31 + 2 * f, 1'b1, 8'd0, f[0], 1'b0);
    end
    drain();
    chk("t2_frames", stat_frames, 4'b1010);
    cfg_rr_en = 1'b0;

    // Backpressure
    clear_stats();
    m_tready = 1'b0;
    beat(32'h40, 1'b0, 8'd1, 1'b1, 1'b0);
    beat(32'h41, 1'b0, 8'd1, 1'b1, 1'b0);
    chk("bp_head", m_tdata, 32'h40);
    s_tvalid = 1'b1; s_tdata = 32'h42; s_tkeep = 4'h2; s_tuser = 1'b0;
    s_tlast = 1'b0; s_tdest = 8'd1;
    repeat (2) @(negedge clk);
    chk("bp_tready", s_tready, 0);
    chk("bp_tvalid", m_tvalid, 1);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    beat(32'h42, 1'b0, 8'd1, 1'b1, 1'b0);
    beat(32'h43, 1'b1, 8'd1, 1'b1, 1'b0);
    drain();
    chk("t3_frames", stat_frames, 4'b0100);

    // Drop mask, then config changes mid-frame
    clear_stats();
    cfg_drop_mask = 2'b10;
    beat(32'h50, 1'b0, 8'd1, 1'b1, 1'b1);
    beat(32'h51, 1'b1, 8'd1, 1'b1, 1'b1);
    drain();
    chk("t4_dropped", stat_dropped, 1);
    chk("t4_frames", stat_frames, 0);
    cfg_drop_mask = 2'b00;
    beat(32'h60, 1'b0, 8'd0, 1'b0, 1'b0);
    cfg_drop_mask = 2'b01;
    cfg_rr_en = 1'b1;
    beat(32'h61, 1'b0, 8'd1, 1'b0, 1'b0);
    beat(32'h62, 1'b1, 8'd1, 1'b0, 1'b0);
    drain();
    chk("t4_mid_frames", stat_frames, 4'b0001);
    chk("t4_mid_dropped", stat_dropped, 1);
    cfg_drop_mask = 2'b00;
    cfg_rr_en = 1'b0;

    // cfg_enable deasserted mid-frame
    clear_stats();
    beat(32'h70, 1'b0, 8'd0, 1'b0, 1'b0);
    cfg_enable = 1'b0;
    beat(32'h71, 1'b0, 8'd0, 1'b0, 1'b0);
    beat(32'h72, 1'b1, 8'd0, 1'b0, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'h80; s_tkeep = 4'h0; s_tuser = 1'b0;
    s_tlast = 1'b1; s_tdest = 8'd1;
    repeat (3) @(negedge clk);
    chk("dis_tready", s_tready, 0);
    drain();
    chk("dis_tready2", s_tready, 0);
    chk("dis_frames", stat_frames, 4'b0001);
    cfg_enable = 1'b1;
    beat(32'h80, 1'b1, 8'd1, 1'b1, 1'b0);
    drain();
    chk("en_frames", stat_frames, 4'b0101);

    // Counter wrap and clear coincident with tlast
    clear_stats();
    for (int i = 0; i < 5; i++) beat(32'h90 + i, 1'b1, 8'd0, 1'b0, 1'b0);
    drain();
    chk("wrap", stat_frames, 4'b0001);
    stat_clear = 1'b1;
    beat(32'hA0, 1'b1, 8'd0, 1'b0, 1'b0);
    stat_clear = 1'b0;
    drain();
    chk("clr_tlast", {stat_frames, stat_dropped}, 0);

    // Reset in the middle of a frame
    cfg_rr_en = 1'b1;
    beat(32'hB0, 1'b1, 8'd0, 1'b0, 1'b0);
    drain();
    m_tready = 1'b0;
    send_beat(32'hB1, 1'b0, 8'd0);
    chk("pre_rst_frames", stat_frames, 4'b0001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_stats", stat_frames, 0);
    rst = 1'b0;
    m_tready = 1'b1;
    beat(32'hC0, 1'b0, 8'd0, 1'b0, 1'b0);
    beat(32'hC1, 1'b1, 8'd0, 1'b0, 1'b0);
    drain();
    chk("post_rst_frames", stat_frames, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_steer_ctrl.md
Name: axis_steer_ctrl

Overview:
- Steering front-end placed directly upstream of the 2-port AXI4-Stream demux.
- Registers the incoming stream through a 2-entry skid buffer and decides a route per frame, either from tdest bit 0 or by round-robin.
- Drives the demux sel/drop inputs beat-aligned with the data, holding them constant for the whole frame.
- Keeps per-port frame counters and a dropped-frame counter.

Parameters:
DATA_WIDTH, 32, tdata width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
DEST_WIDTH, 8, tdest width (must be >=1)
USER_WIDTH, 1, tuser width
COUNT_WIDTH, 16, width of each statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of frame
s_axis_tdest  in  DEST_WIDTH  destination; bit 0 is the route in tdest mode
s_axis_tuser  in  USER_WIDTH  user sideband
m_axis_tdata/tkeep/tvalid/tready/tlast/tdest/tuser  out/out/out/in/out/out/out  as input  registered stream to demux
sel  out  1  demux port select, aligned with the m_axis head beat
drop  out  1  demux drop, aligned with the m_axis head beat
cfg_enable  in  1  0 = accept no new frames (a frame in progress completes)
cfg_rr_en  in  1  1 = round-robin routing, 0 = tdest[0] routing
cfg_drop_mask  in  2  bit i set = drop frames routed to port i
stat_clear  in  1  synchronous clear of all counters
stat_frames  out  2*COUNT_WIDTH  frames forwarded; port0 in [COUNT_WIDTH-1:0]
stat_dropped  out  COUNT_WIDTH  frames marked drop

Behaviour:
- Reset: all outputs 0 (m_axis_tvalid, s_axis_tready, sel, drop, counters); buffer count=0; in_frame=0; rr_ptr=0. Reset mid-frame discards buffered beats; the next accepted beat is treated as a frame start.
- Skid buffer: 2-entry FIFO; each entry holds {tdata, tkeep, tlast, tdest, tuser, sel, drop}.
  - m_axis_* and sel/drop come from the head entry; m_axis_tvalid = (count!=0).
  - Latency: 1 cycle from input accept to m_axis_tvalid.
  - Simultaneous push and pop with count=2 is not possible (ready is low); with count=1 the count stays 1.
- Ready: s_axis_tready = !rst && count<2 && (in_frame || cfg_enable). There is no combinational path from m_axis_tready.
- Route decision, only on an accepted beat with in_frame=0 (frame start):
  - route = cfg_rr_en ? rr_ptr : s_axis_tdest[0]
  - drp = cfg_drop_mask[route]
  - Latch route/drp into cur_sel/cur_drop.
  - If cfg_rr_en, toggle rr_ptr (toggled per frame start, including dropped frames).
  - Later beats of the frame use the latched cur_sel/cur_drop; changes to cfg_* mid-frame have no effect until the next frame start.
- in_frame: set on an accepted non-last beat; cleared on an accepted tlast. A single-beat frame (tlast on its first beat) leaves in_frame=0.
- State machine: IDLE (in_frame=0) -> FRAME on an accepted beat with tlast=0; FRAME -> IDLE on an accepted tlast. cfg_enable=0 blocks only the IDLE accept.
- Counters, updated on an input-side accepted tlast using the frame's route/drop:
  - drop=1: stat_dropped+1
  - drop=0: stat_frames[route]+1
  - All counters wrap modulo 2^COUNT_WIDTH.
  - stat_clear wins over a same-cycle increment (result 0).
- The integrator ties demux enable high; drop frames still flow through this block and are discarded by the demux.

Test Plan:
- Reset, then tdest mode: send 3-beat frame tdest=1, then 1-beat frame tdest=0, m_tready=1 -> m_axis beats 1 cycle after input; sel=1,1,1 then 0; stat_frames port1=1, port0=1.
- Round-robin: cfg_rr_en=1, four 2-beat frames with tdest=0 -> sel per frame 0,1,0,1; stat_frames = {2,2}.
- Backpressure: hold m_tready=0 and stream continuously -> s_tready drops after 2 accepts; release -> no beat lost or duplicated; order and sel alignment preserved.
- Drop and mid-frame config: cfg_drop_mask=2'b10, frame to port1 -> drop=1 on all beats, stat_dropped=1. Separately, change cfg_drop_mask/cfg_rr_en mid-frame -> current frame's sel/drop unchanged.
- cfg_enable=0 asserted mid-frame -> remaining beats accepted through tlast, then s_tready=0 until cfg_enable=1.
- Wrap and clear: COUNT_WIDTH=2, five frames to port0 -> stat_frames port0=1. stat_clear coincident with tlast -> counters read 0. Reset during FRAME -> m_tvalid=0 next cycle and the next beat starts a new frame with a fresh route.
